// File: rtl/cast_output_port_stage_if.sv
// Output link of one router port: flit data with its one-hot VC, valid/ready handshake.
`ifndef PN
`define PN 5
`endif
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 32
`endif

interface cast_output_port_stage_if;
  logic [`DW-1:0] data;
  logic [`VN-1:0] vc;
  logic           valid;
  logic           ready;

  modport master (output data, output vc, output valid, input ready);
  modport slave  (input data, input vc, input valid, output ready);
endinterface

// File: rtl/cast_output_port_stage.sv
// Per-output-port switch stage: round-robin over every (input port, VC) requester
// targeting this port, one transfer per cycle into a 2-entry link buffer.
`ifndef PN
`define PN 5
`endif
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 32
`endif

module cast_output_port_stage #(
  parameter int PORT_ID = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [`DW-1:0]        data_i     [`PN][`VN],
  input  logic                  valid_i    [`PN][`VN],
  input  logic [`PN-1:0]        req_port_i [`PN][`VN],
  output logic                  ready_o    [`PN][`VN],
  cast_output_port_stage_if.master link
);

  localparam int N  = `PN * `VN;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [`DW-1:0] req_data [N];
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic [PW-1:0]  cand;
  logic           found;
  logic           grant;
  logic           pop;
  logic [`VN-1:0] win_vc;
  logic [`DW-1:0] win_data;
  logic [1:0]     count;
  logic [`DW-1:0] head_data, tail_data;
  logic [`VN-1:0] head_vc, tail_vc;
  int             idx;

  always_comb begin
    req = '0;
    for (int p = 0; p < `PN; p++) begin
      for (int v = 0; v < `VN; v++) begin
        req[p*`VN+v]      = valid_i[p][v] & req_port_i[p][v][PORT_ID];
        req_data[p*`VN+v] = data_i[p][v];
      end
    end
  end

  // Search starts at ptr and wraps explicitly at N, which need not be a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant depends only on requests, ptr and registered occupancy, never on the link ready.
  assign grant    = found && (count != 2'd2) && rstn;
  assign win_vc   = `VN'(1) << (int'(win) % `VN);
  assign win_data = req_data[win];
  assign pop      = (count != 2'd0) && link.ready;

  always_comb begin
    for (int p = 0; p < `PN; p++) begin
      for (int v = 0; v < `VN; v++) begin
        ready_o[p][v] = grant && (int'(win) == p*`VN+v);
      end
    end
  end

  // Head entry always holds the oldest flit and is zero when the buffer is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr       <= '0;
      count     <= 2'd0;
      head_data <= '0;
      head_vc   <= '0;
      tail_data <= '0;
      tail_vc   <= '0;
    end else begin
      if (grant) begin
        if (int'(win) == N-1) ptr <= '0;
        else                  ptr <= win + 1'b1;
      end
      case ({grant, pop})
        2'b11: begin
          head_data <= win_data;
          head_vc   <= win_vc;
        end
        2'b01: begin
          head_data <= tail_data;
          head_vc   <= tail_vc;
          tail_data <= '0;
          tail_vc   <= '0;
          count     <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= win_data;
            head_vc   <= win_vc;
          end else begin
            tail_data <= win_data;
            tail_vc   <= win_vc;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign link.data  = head_data;
  assign link.vc    = head_vc;
  assign link.valid = (count != 2'd0);

endmodule

// File: tb/tb_cast_output_port_stage.sv
// Bench for cast_output_port_stage: queue/modulo reference model checked every cycle,
// plus directed scenarios with hand-computed grant and drain orders.
`ifndef PN
`define PN 5
`endif
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 32
`endif

module tb_cast_output_port_stage;
  localparam int PN      = `PN;
  localparam int VN      = `VN;
  localparam int DW      = `DW;
  localparam int N       = PN * VN;
  localparam int PORT_ID = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [VN-1:0] vc;
  } flit_t;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          ready_i;
  logic [DW-1:0] data_i     [PN][VN];
  logic          valid_i    [PN][VN];
  logic [PN-1:0] req_port_i [PN][VN];
  logic          ready_o    [PN][VN];
  int            remaining  [PN][VN];

  cast_output_port_stage_if link ();
  assign link.ready = ready_i;

  cast_output_port_stage #(.PORT_ID(PORT_ID)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .req_port_i (req_port_i),
    .ready_o    (ready_o),
    .link       (link)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  flit_t         mq [$];
  int            mptr = 0;
  int            gnt_log [$];
  logic [DW-1:0] pop_log [$];
  int            run_len, max_run, max_count;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue occupancy and a modulo-N round-robin search from the model pointer.
  always @(negedge clk) begin : compare
    int            exp_w;
    int            r;
    bit            exp_g;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  got_rdy;
    flit_t         f;
    got_rdy = '0;
    for (int p = 0; p < PN; p++)
      for (int v = 0; v < VN; v++)
        got_rdy[p*VN+v] = ready_o[p][v];
    for (int i = 0; i < N; i++)
      if (got_rdy[i]) gnt_log.push_back(i);
    if (link.valid && ready_i) pop_log.push_back(link.data);
    if (!rstn) begin
      mq.delete();
      mptr = 0;
      checkOutput("rst_ready_o", 64'(got_rdy), 64'd0);
      checkOutput("rst_valid_o", 64'(link.valid), 64'd0);
      checkOutput("rst_data_o", 64'(link.data), 64'd0);
      checkOutput("rst_vc_o", 64'(link.vc), 64'd0);
    end else begin
      exp_w = -1;
      for (int k = 0; k < N; k++) begin
        r = (mptr + k) % N;
        if (exp_w < 0 && valid_i[r/VN][r%VN] && req_port_i[r/VN][r%VN][PORT_ID]) exp_w = r;
      end
      exp_g   = (exp_w >= 0) && (mq.size() < 2);
      exp_rdy = exp_g ? (N'(1) << exp_w) : '0;
      checkOutput("ready_o", 64'(got_rdy), 64'(exp_rdy));
      checkOutput("valid_o", 64'(link.valid), 64'(mq.size() != 0));
      checkOutput("data_o", 64'(link.data), (mq.size() != 0) ? 64'(mq[0].d) : 64'd0);
      checkOutput("vc_o", 64'(link.vc), (mq.size() != 0) ? 64'(mq[0].vc) : 64'd0);
      if (mq.size() != 0 && ready_i) void'(mq.pop_front());
      if (exp_g) begin
        f.d  = data_i[exp_w/VN][exp_w%VN];
        f.vc = VN'(1) << (exp_w % VN);
        mq.push_back(f);
        mptr = (exp_w + 1) % N;
      end
    end
  end

  task automatic clearAll();
    for (int p = 0; p < PN; p++)
      for (int v = 0; v < VN; v++) begin
        data_i[p][v]     = '0;
        valid_i[p][v]    = 1'b0;
        req_port_i[p][v] = '0;
        remaining[p][v]  = 0;
      end
  endtask

  task automatic setReq(input int p, input int v, input logic [DW-1:0] d,
                        input logic [PN-1:0] mask, input int n);
    data_i[p][v]     = d;
    req_port_i[p][v] = mask;
    valid_i[p][v]    = 1'b1;
    remaining[p][v]  = n;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    clearAll();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // Emulates the input stages: a granted requester advances to its next flit or drops valid.
  task automatic applyStimulus(input int cycles);
    logic granted [PN][VN];
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (link.valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (int'(dut.count) > max_count) max_count = int'(dut.count);
      for (int p = 0; p < PN; p++)
        for (int v = 0; v < VN; v++)
          granted[p][v] = ready_o[p][v];
      @(posedge clk); #1;
      for (int p = 0; p < PN; p++)
        for (int v = 0; v < VN; v++)
          if (granted[p][v]) begin
            remaining[p][v]--;
            data_i[p][v]++;
            valid_i[p][v] = (remaining[p][v] > 0);
          end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_fair [6] = '{0, 5, 19, 0, 5, 19};
    logic [DW-1:0] exp_drain [4] = '{32'h200, 32'h700, 32'hA00, 32'hD00};

    clearAll();
    ready_i = 1'b1;
    rstn    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk); #1;
    checkOutput("reset_valid", 64'(link.valid), 64'd0);
    checkOutput("reset_ptr", 64'(dut.ptr), 64'd0);

    // Single requester, input 1 VC 3
    @(posedge clk); #1;
    setReq(1, 3, 32'hA5A5_0001, 5'b00100, 1);
    @(negedge clk); #1;
    checkOutput("single_grant", 64'(ready_o[1][3]), 64'd1);
    @(posedge clk); #1;
    valid_i[1][3] = 1'b0;
    @(negedge clk); #1;
    checkOutput("single_data", 64'(link.data), 64'hA5A5_0001);
    checkOutput("single_vc", 64'(link.vc), 64'b1000);
    checkOutput("single_valid", 64'(link.valid), 64'd1);
    checkOutput("single_ptr", 64'(dut.ptr), 64'd8);
    applyStimulus(2);

    // Fairness among r=0, 5, 19 from reset
    doReset();
    setReq(0, 0, 32'h100, 5'b00100, 100);
    setReq(1, 1, 32'h500, 5'b00100, 100);
    setReq(4, 3, 32'h1900, 5'b00100, 100);
    gnt_log.delete();
    applyStimulus(6);
    checkOutput("fair_len", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("fair_order%0d", i),
                  (i < gnt_log.size()) ? 64'(gnt_log[i]) : 64'hFFFF, 64'(exp_fair[i]));
    clearAll();
    applyStimulus(3);

    // Request for a different output port
    setReq(0, 0, 32'h77, 5'b00010, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checkOutput("nomatch_ready", 64'(ready_o[0][0]), 64'd0);
      checkOutput("nomatch_valid", 64'(link.valid), 64'd0);
    end
    @(posedge clk); #1;
    clearAll();

    // Backpressure with four requesters
    doReset();
    ready_i = 1'b0;
    setReq(0, 2, 32'h200, 5'b00100, 1);
    setReq(1, 3, 32'h700, 5'b00100, 1);
    setReq(2, 2, 32'hA00, 5'b00100, 1);
    setReq(3, 1, 32'hD00, 5'b00100, 1);
    gnt_log.delete();
    applyStimulus(5);
    checkOutput("bp_grants", 64'(gnt_log.size()), 64'd2);
    checkOutput("bp_first", (gnt_log.size() > 0) ? 64'(gnt_log[0]) : 64'hFFFF, 64'd2);
    checkOutput("bp_second", (gnt_log.size() > 1) ? 64'(gnt_log[1]) : 64'hFFFF, 64'd7);
    checkOutput("bp_hold_data", 64'(link.data), 64'h200);
    pop_log.delete();
    ready_i = 1'b1;
    applyStimulus(6);
    checkOutput("drain_len", 64'(pop_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("drain%0d", i),
                  (i < pop_log.size()) ? 64'(pop_log[i]) : 64'hFFFF_FFFF_FFFF, 64'(exp_drain[i]));

    // Streaming throughput, 8 flits from input 3 VC 0
    setReq(3, 0, 32'h3000, 5'b00100, 8);
    run_len   = 0;
    max_run   = 0;
    max_count = 0;
    applyStimulus(12);
    checkOutput("thru_run", 64'(max_run), 64'd8);
    checkOutput("thru_maxcount", 64'(max_count), 64'd1);

    // Reset while the buffer is full
    ready_i = 1'b0;
    setReq(1, 0, 32'h400, 5'b00100, 1);
    setReq(1, 2, 32'h600, 5'b00100, 1);
    applyStimulus(3);
    checkOutput("full_count", 64'(dut.count), 64'd2);
    rstn = 1'b0;
    #1;
    checkOutput("async_valid", 64'(link.valid), 64'd0);
    checkOutput("async_data", 64'(link.data), 64'd0);
    @(posedge clk); #1;
    rstn    = 1'b1;
    ready_i = 1'b1;
    setReq(0, 3, 32'h300, 5'b00100, 1);
    setReq(3, 3, 32'hF00, 5'b00100, 1);
    gnt_log.delete();
    applyStimulus(4);
    checkOutput("post_rst_first", (gnt_log.size() > 0) ? 64'(gnt_log[0]) : 64'hFFFF, 64'd3);
    checkOutput("post_rst_second", (gnt_log.size() > 1) ? 64'(gnt_log[1]) : 64'hFFFF, 64'd15);

    clearAll();
    applyStimulus(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
